link_table_controller: RTL and testbench

LINK_TABLE_CONTROLLER -- requirements
Module: link_table_controller

---
 rtl/link_table_controller.sv | 136 +++++++++++++
 tb/tb_link_table_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_table_controller.sv
// Free-page link-table controller: keeps the free list as a singly linked list
// in an external synchronous RAM and hands out / takes back page numbers.
module link_table_controller #(
  parameter int unsigned PAGE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [PAGE_W-1:0] init_addr,
  input  logic [PAGE_W-1:0] init_data,
  input  logic              alloc_req,
  output logic              alloc_ack,
  output logic [PAGE_W-1:0] alloc_page,
  input  logic              free_req,
  input  logic [PAGE_W-1:0] free_page,
  output logic              free_ack,
  output logic              empty,
  output logic [PAGE_W:0]   free_count,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [PAGE_W-1:0] mem_addr,
  output logic [PAGE_W-1:0] mem_wdata,
  input  logic [PAGE_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = PAGE_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = {1'b1, {PAGE_W{1'b0}}};
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = {PAGE_W{1'b1}};

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    A_RD   = 3'd2,
    A_DONE = 3'd3,
    F_WR   = 3'd4
  } state_t;

  state_t            state;
  logic [PAGE_W-1:0] head;
  logic [PAGE_W-1:0] tail;

  // Control FSM, list pointers, counters and acknowledge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      free_count <= '0;
      empty      <= 1'b1;
      alloc_page <= '0;
      alloc_ack  <= 1'b0;
      free_ack   <= 1'b0;
    end else begin
      alloc_ack <= 1'b0;
      free_ack  <= 1'b0;
      case (state)
        INIT: begin
          if (init_done) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= LAST_PAGE;
            free_count <= FULL_CNT;
            empty      <= 1'b0;
          end
        end
        IDLE: begin
          // Frees win so a stalled alloc can always be unblocked.
          if (free_req) begin
            state    <= F_WR;
            free_ack <= 1'b1;
          end else if (alloc_req && !empty) begin
            state <= A_RD;
          end
        end
        A_RD: begin
          state      <= A_DONE;
          alloc_ack  <= 1'b1;
          alloc_page <= head;
        end
        A_DONE: begin
          state <= IDLE;
          // Last page out: the link word is meaningless, keep head as is.
          if (free_count != ONE_CNT) begin
            head <= mem_rdata;
          end
          free_count <= free_count - ONE_CNT;
          empty      <= (free_count == ONE_CNT);
        end
        F_WR: begin
          state <= IDLE;
          if (empty) begin
            head       <= free_page;
            tail       <= free_page;
            free_count <= ONE_CNT;
            empty      <= 1'b0;
          end else begin
            tail <= free_page;
            if (free_count != FULL_CNT) begin
              free_count <= free_count + ONE_CNT;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Link RAM port: initializer during INIT, list walk/append otherwise.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      INIT: begin
        mem_wr_en = ~init_done & ~rst;
        mem_addr  = init_addr;
        mem_wdata = init_data;
      end
      A_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = head;
      end
      F_WR: begin
        if (!empty) begin
          mem_wr_en = 1'b1;
          mem_addr  = tail;
          mem_wdata = free_page;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_link_table_controller.sv
// Scoreboard bench for link_table_controller: a 4096-page and a 4-page instance
// checked against a FIFO-of-free-pages reference model.
module tb_link_table_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        init_done [2];
  logic [11:0] init_addr [2];
  logic [11:0] init_data [2];
  logic        alloc_req [2];
  logic        free_req  [2];
  logic [11:0] free_page [2];
  logic [11:0] mem_rdata [2];

  wire         alloc_ack  [2];
  wire         free_ack   [2];
  wire         empty      [2];
  wire         mem_wr_en  [2];
  wire         mem_rd_en  [2];
  wire  [11:0] alloc_page [2];
  wire  [11:0] mem_addr   [2];
  wire  [11:0] mem_wdata  [2];
  wire  [12:0] free_count [2];

  wire  [1:0]  b_alloc_page;
  wire  [2:0]  b_free_count;
  wire  [1:0]  b_mem_addr;
  wire  [1:0]  b_mem_wdata;

  link_table_controller #(.PAGE_W(12)) u_big (
    .clk(clk), .rst(rst),
    .init_done(init_done[0]), .init_addr(init_addr[0]), .init_data(init_data[0]),
    .alloc_req(alloc_req[0]), .alloc_ack(alloc_ack[0]), .alloc_page(alloc_page[0]),
    .free_req(free_req[0]), .free_page(free_page[0]), .free_ack(free_ack[0]),
    .empty(empty[0]), .free_count(free_count[0]),
    .mem_wr_en(mem_wr_en[0]), .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  link_table_controller #(.PAGE_W(2)) u_small (
    .clk(clk), .rst(rst),
    .init_done(init_done[1]), .init_addr(init_addr[1][1:0]), .init_data(init_data[1][1:0]),
    .alloc_req(alloc_req[1]), .alloc_ack(alloc_ack[1]), .alloc_page(b_alloc_page),
    .free_req(free_req[1]), .free_page(free_page[1][1:0]), .free_ack(free_ack[1]),
    .empty(empty[1]), .free_count(b_free_count),
    .mem_wr_en(mem_wr_en[1]), .mem_rd_en(mem_rd_en[1]), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata[1][1:0])
  );

  assign alloc_page[1] = 12'(b_alloc_page);
  assign free_count[1] = 13'(b_free_count);
  assign mem_addr[1]   = 12'(b_mem_addr);
  assign mem_wdata[1]  = 12'(b_mem_wdata);

  // Link RAMs, 1-cycle read latency.
  logic [11:0] ram0 [4096];
  logic [11:0] ram1 [4];
  always @(posedge clk) begin
    if (mem_wr_en[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    if (mem_rd_en[0]) mem_rdata[0] <= ram0[mem_addr[0]];
    if (mem_wr_en[1]) ram1[mem_addr[1][1:0]] <= mem_wdata[1];
    if (mem_rd_en[1]) mem_rdata[1] <= 12'(ram1[mem_addr[1][1:0]]);
  end

  typedef struct {
    int          inst;
    bit          is_alloc;
    logic [11:0] page;
    int          cnt_after;
    bit          exp_wr;
    logic [11:0] exp_addr;
  } ev_t;

  ev_t         sb [$];
  logic [11:0] fl [$];     // reference free list, front = next page handed out
  logic [11:0] held [$];   // pages currently owned by the bench
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ack, then checks the counters next cycle.
  logic        prev_rd   [2];
  logic [11:0] prev_addr [2];
  bit          post_chk  [2];
  int          post_cnt  [2];
  initial for (int u = 0; u < 2; u++) begin
    post_chk[u] = 1'b0; prev_rd[u] = 1'b0; prev_addr[u] = '0; post_cnt[u] = 0;
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ev_t ev;
      if (post_chk[u]) begin
        check("count_after_ack", free_count[u], post_cnt[u]);
        check("empty_after_ack", empty[u], post_cnt[u] == 0);
        post_chk[u] = 1'b0;
      end
      if (alloc_ack[u] === 1'b1 || free_ack[u] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack inst=%0d alloc_ack=%0b free_ack=%0b at %0t",
                   u, alloc_ack[u], free_ack[u], $time);
        end else begin
          ev = sb.pop_front();
          check("ack_instance", u, ev.inst);
          check("ack_is_alloc", alloc_ack[u], ev.is_alloc);
          check("ack_is_free", free_ack[u], !ev.is_alloc);
          if (ev.is_alloc) begin
            check("alloc_page", alloc_page[u], ev.page);
            check("alloc_rd_en_prev", prev_rd[u], 1);
            check("alloc_rd_addr_prev", prev_addr[u], ev.page);
          end else begin
            check("free_wr_en", mem_wr_en[u], ev.exp_wr);
            if (ev.exp_wr) begin
              check("free_wr_addr", mem_addr[u], ev.exp_addr);
              check("free_wr_data", mem_wdata[u], ev.page);
            end
          end
          post_chk[u] = 1'b1;
          post_cnt[u] = ev.cnt_after;
        end
      end
      prev_rd[u]   = mem_rd_en[u];
      prev_addr[u] = mem_addr[u];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input int u, input bit is_alloc, input logic [11:0] page);
    ev_t ev;
    ev.inst = u; ev.is_alloc = is_alloc; ev.page = page; ev.exp_wr = 1'b0; ev.exp_addr = '0;
    if (is_alloc) begin
      ev.page = fl.pop_front();
      held.push_back(ev.page);
    end else begin
      ev.exp_wr = (fl.size() != 0);
      if (ev.exp_wr) ev.exp_addr = fl[$];
      fl.push_back(page);
    end
    ev.cnt_after = fl.size();
    sb.push_back(ev);
  endtask

  task automatic wait_ack_drop(input int u, input bit is_alloc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 50) begin
      tick();
      cyc++;
      seen = is_alloc ? (alloc_ack[u] === 1'b1) : (free_ack[u] === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout inst=%0d no ack within 50 cycles", is_alloc ? "alloc" : "free", u);
      sb.delete();
      cyc = -1;
    end else begin
      tick();
    end
    if (is_alloc) alloc_req[u] = 1'b0;
    else free_req[u] = 1'b0;
  endtask

  task automatic do_req(input int u, input bit is_alloc, input logic [11:0] page);
    int cyc;
    push_expect(u, is_alloc, page);
    if (is_alloc) alloc_req[u] = 1'b1;
    else begin
      free_page[u] = page;
      free_req[u]  = 1'b1;
    end
    wait_ack_drop(u, is_alloc, cyc);
    if (cyc >= 0) check(is_alloc ? "alloc_latency" : "free_latency", cyc, is_alloc ? 2 : 1);
  endtask

  task automatic take_held(input logic [11:0] page);
    for (int i = 0; i < held.size(); i++) begin
      if (held[i] == page) begin
        held.delete(i);
        break;
      end
    end
  endtask

  task automatic reset_init(input int u, input int n);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      alloc_req[k] = 1'b0; free_req[k] = 1'b0; free_page[k] = '0;
    end
    init_done[u] = 1'b0; init_addr[u] = '0; init_data[u] = '0;
    repeat (3) tick();
    check("rst_alloc_ack", alloc_ack[u], 0);
    check("rst_free_ack", free_ack[u], 0);
    check("rst_rd_en", mem_rd_en[u], 0);
    check("rst_wr_en", mem_wr_en[u], 0);
    check("rst_free_count", free_count[u], 0);
    check("rst_empty", empty[u], 1);
    check("rst_alloc_page", alloc_page[u], 0);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      init_addr[u] = 12'(i);
      init_data[u] = 12'(i + 1);
      #1;
      check("init_wr_en", mem_wr_en[u], 1);
      if (i == 0 || i == n - 1) begin
        check("init_addr_mux", mem_addr[u], i);
        check("init_data_mux", mem_wdata[u], 12'(i + 1) & 12'(n - 1));
      end
      tick();
    end
    init_done[u] = 1'b1;
    #1;
    check("init_done_wr_off", mem_wr_en[u], 0);
    check("init_count_pre", free_count[u], 0);
    tick();
    check("idle_free_count", free_count[u], n);
    check("idle_empty", empty[u], 0);
    check("idle_mem_quiet", {mem_wr_en[u], mem_rd_en[u]}, 0);
    fl.delete();
    held.delete();
    for (int i = 0; i < n; i++) fl.push_back(12'(i));
  endtask

  task automatic random_ops(input int u, input int nops);
    bit          pick_alloc;
    int          idx;
    logic [11:0] p;
    for (int k = 0; k < nops; k++) begin
      if (fl.size() == 0) pick_alloc = 1'b0;
      else if (held.size() == 0) pick_alloc = 1'b1;
      else pick_alloc = ($urandom_range(0, 1) == 1);
      if (pick_alloc) do_req(u, 1'b1, '0);
      else begin
        idx = $urandom_range(0, held.size() - 1);
        p = held[idx];
        held.delete(idx);
        do_req(u, 1'b0, p);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      init_done[k] = 1'b0; init_addr[k] = '0; init_data[k] = '0;
      alloc_req[k] = 1'b0; free_req[k] = 1'b0; free_page[k] = '0;
    end

    // 4096-page instance: init, first allocs, free, simultaneous requests.
    reset_init(0, 4096);
    do_req(0, 1'b1, '0);
    do_req(0, 1'b1, '0);
    take_held(12'd0);
    do_req(0, 1'b0, 12'd0);

    take_held(12'd1);
    push_expect(0, 1'b0, 12'd1);
    push_expect(0, 1'b1, '0);
    free_page[0] = 12'd1;
    free_req[0]  = 1'b1;
    alloc_req[0] = 1'b1;
    fork
      wait_ack_drop(0, 1'b0, c1);
      wait_ack_drop(0, 1'b1, c2);
    join
    check("simul_free_latency", c1, 1);
    check("simul_alloc_gap", c2 - c1, 3);
    random_ops(0, 40);

    // 4-page instance: drain, stall on empty, unblock with a free.
    reset_init(1, 4);
    repeat (4) do_req(1, 1'b1, '0);
    check("drained_empty", empty[1], 1);
    alloc_req[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_no_ack", alloc_ack[1], 0);
      check("stall_no_rd", mem_rd_en[1], 0);
      check("stall_empty", empty[1], 1);
    end
    take_held(12'd2);
    push_expect(1, 1'b0, 12'd2);
    push_expect(1, 1'b1, '0);
    free_page[1] = 12'd2;
    free_req[1]  = 1'b1;
    fork
      wait_ack_drop(1, 1'b0, c1);
      wait_ack_drop(1, 1'b1, c2);
    join
    random_ops(1, 200);

    // Reset in the middle of an allocation.
    if (fl.size() == 0) begin
      c1 = 0;
      free_page[1] = held[0];
      do_req(1, 1'b0, held.pop_front());
    end
    alloc_req[1] = 1'b1;
    tick();
    check("pre_abort_rd_en", mem_rd_en[1], 1);
    rst = 1'b1;
    #1;
    check("abort_rd_en", mem_rd_en[1], 0);
    check("abort_wr_en", mem_wr_en[1], 0);
    check("abort_alloc_ack", alloc_ack[1], 0);
    check("abort_free_count", free_count[1], 0);
    check("abort_empty", empty[1], 1);
    alloc_req[1] = 1'b0;
    init_done[1] = 1'b0;
    repeat (3) begin
      tick();
      check("abort_no_ack", alloc_ack[1], 0);
    end
    rst = 1'b0;
    #1;
    check("reinit_wr_en", mem_wr_en[1], 1);
    check("reinit_free_count", free_count[1], 0);
    alloc_req[1] = 1'b1;
    repeat (5) begin
      tick();
      check("init_ignores_req", alloc_ack[1], 0);
      check("init_no_rd", mem_rd_en[1], 0);
    end
    alloc_req[1] = 1'b0;
    tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
